// File: rtl/rsa_host.sv
// rsa_host: streams operand bytes into the rsa core register file, starts the
// core, waits for completion and streams the 256-bit result back out.
module rsa_host #(
  parameter int NBYTES  = 32,
  parameter int HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       core_we,
  output logic       core_oe,
  output logic       core_start,
  output logic [1:0] core_reg_sel,
  output logic [4:0] core_addr,
  output logic [7:0] core_wdata,
  input  logic [7:0] core_rdata,
  input  logic       core_ready
);
  localparam int BW = $clog2(3*NBYTES + 1);
  localparam int RW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam logic [BW-1:0] BLAST = BW'(3*NBYTES - 1);
  localparam logic [RW-1:0] RLAST = RW'(NBYTES - 1);

  typedef enum logic [2:0] {LOAD, WR, START, WAIT, RD, SEND} state_t;

  state_t        state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          in_ready_n, out_valid_n, busy_n;
  logic          we_n, oe_n, start_n;
  logic [7:0]    out_data_n, wdata_n;
  logic [1:0]    sel_n;
  logic [4:0]    addr_n;

  // State and every output register; reset puts the port in its idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD;
      bcnt         <= '0;
      rcnt         <= '0;
      hcnt         <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
      busy         <= 1'b0;
      core_we      <= 1'b1;
      core_oe      <= 1'b1;
      core_start   <= 1'b0;
      core_reg_sel <= 2'd0;
      core_addr    <= 5'd0;
      core_wdata   <= 8'h00;
    end else begin
      state        <= state_n;
      bcnt         <= bcnt_n;
      rcnt         <= rcnt_n;
      hcnt         <= hcnt_n;
      in_ready     <= in_ready_n;
      out_valid    <= out_valid_n;
      out_data     <= out_data_n;
      busy         <= busy_n;
      core_we      <= we_n;
      core_oe      <= oe_n;
      core_start   <= start_n;
      core_reg_sel <= sel_n;
      core_addr    <= addr_n;
      core_wdata   <= wdata_n;
    end
  end

  // Next-state and next-output values; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_n     = state;
    bcnt_n      = bcnt;
    rcnt_n      = rcnt;
    hcnt_n      = hcnt;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    we_n        = 1'b1;
    oe_n        = 1'b1;
    start_n     = 1'b0;
    sel_n       = core_reg_sel;
    addr_n      = core_addr;
    wdata_n     = core_wdata;
    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          wdata_n    = in_data;
          we_n       = 1'b0;
          sel_n      = 2'(32'(bcnt) / NBYTES + 1);
          addr_n     = 5'(32'(bcnt) % NBYTES);
          in_ready_n = 1'b0;
          state_n    = WR;
        end
      end
      WR: begin
        bcnt_n = bcnt + 1'b1;
        if (bcnt == BLAST) begin
          start_n = 1'b1;
          state_n = START;
        end else begin
          in_ready_n = 1'b1;
          state_n    = LOAD;
        end
      end
      START: begin
        hcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // The START cycle counts as the first ignored cycle, so RD begins
        // HOLDOFF+1 cycles after the start pulse when the core is already ready.
        if (32'(hcnt) + 1 < HOLDOFF) begin
          hcnt_n = hcnt + 1'b1;
        end else if (core_ready) begin
          oe_n    = 1'b0;
          sel_n   = 2'd0;
          addr_n  = 5'(rcnt);
          state_n = RD;
        end
      end
      RD: begin
        out_data_n  = core_rdata;
        out_valid_n = 1'b1;
        state_n     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (rcnt == RLAST) begin
            rcnt_n     = '0;
            bcnt_n     = '0;
            in_ready_n = 1'b1;
            state_n    = LOAD;
          end else begin
            rcnt_n  = rcnt + 1'b1;
            oe_n    = 1'b0;
            addr_n  = 5'(rcnt + 1'b1);
            state_n = RD;
          end
        end
      end
      default: state_n = LOAD;
    endcase
    busy_n = (state_n != LOAD) || (bcnt_n != '0);
  end

endmodule
